// File: rtl/counter_monitor_if.sv
// Observation bus between the up/down counter and its run-time health monitor.
// The counter side drives cnt as master; the monitor drives the status fields as slave.
interface counter_monitor_if #(
    parameter int W  = 10,
    parameter int EW = 8
);
    logic signed [W-1:0] cnt;
    logic                mode_est;
    logic                dir_valid;
    logic                sat_hi;
    logic                sat_lo;
    logic                err;
    logic                fault;
    logic [EW-1:0]       err_count;

    modport master (
        output cnt,
        input  mode_est, dir_valid, sat_hi, sat_lo, err, fault, err_count
    );

    modport slave (
        input  cnt,
        output mode_est, dir_valid, sat_hi, sat_lo, err, fault, err_count
    );
endinterface

// File: rtl/counter_monitor.sv
// Passive health monitor for the +5/-9 saturating counter that skips INV: reconstructs
// the step direction, flags illegal transitions and keeps a sticky fault plus a saturating tally.
module counter_monitor #(
    parameter int W       = 10,
    parameter int RST_VAL = -50,
    parameter int MIN     = -230,
    parameter int MAX     = 235,
    parameter int INV     = -11,
    parameter int STEP_UP = 5,
    parameter int STEP_DN = 9,
    parameter int EW      = 8
) (
    input  logic               clk,
    input  logic               rst,
    counter_monitor_if.slave   mon
);
    localparam int XW = W + 2;

    localparam logic signed [W-1:0]  RST_VAL_W = W'(RST_VAL);
    localparam logic signed [XW-1:0] MIN_X     = XW'(MIN);
    localparam logic signed [XW-1:0] MAX_X     = XW'(MAX);
    localparam logic signed [XW-1:0] INV_X     = XW'(INV);
    localparam logic signed [XW-1:0] UP_X      = XW'(STEP_UP);
    localparam logic signed [XW-1:0] DN_X      = XW'(STEP_DN);

    localparam logic [0:0] ST_ARMED = 1'b0;
    localparam logic [0:0] ST_TRACK = 1'b1;

    logic [0:0]          state_q, state_d;
    logic signed [W-1:0] prev_q;
    logic                mode_est_q, mode_est_d;
    logic                dir_valid_q, dir_valid_d;
    logic                sat_hi_q, sat_hi_d;
    logic                sat_lo_q, sat_lo_d;
    logic                err_q, err_d;
    logic                fault_q, fault_d;
    logic [EW-1:0]       err_count_q, err_count_d;

    logic signed [XW-1:0] p_x, c_x, up_x, up2_x, dn_x, dn2_x;
    logic                 c_bad, up_hit, dn_hit, illegal;

    assign p_x   = {{2{prev_q[W-1]}}, prev_q};
    assign c_x   = {{2{mon.cnt[W-1]}}, mon.cnt};
    assign up_x  = p_x + UP_X;
    assign up2_x = up_x + UP_X;
    assign dn_x  = p_x - DN_X;
    assign dn2_x = dn_x - DN_X;

    assign c_bad  = (c_x < MIN_X) || (c_x > MAX_X) || (c_x == INV_X);
    assign up_hit = !c_bad && (((up_x <= MAX_X) && (up_x != INV_X) && (c_x == up_x)) ||
                               ((up_x == INV_X) && (c_x == up2_x)) ||
                               ((up_x > MAX_X) && (c_x == p_x)));
    assign dn_hit = !c_bad && (((dn_x >= MIN_X) && (dn_x != INV_X) && (c_x == dn_x)) ||
                               ((dn_x == INV_X) && (c_x == dn2_x)) ||
                               ((dn_x < MIN_X) && (c_x == p_x)));

    // A wrong value held during reset is the only thing reported on the first edge after it.
    assign illegal = (state_q == ST_ARMED && prev_q != RST_VAL_W) || !(up_hit || dn_hit);

    // NOTE: every next-state value gets a default first so this block cannot infer a latch.
    always_comb begin
        state_d     = ST_TRACK;
        mode_est_d  = mode_est_q;
        dir_valid_d = 1'b0;
        sat_hi_d    = 1'b0;
        sat_lo_d    = 1'b0;
        err_d       = 1'b0;
        fault_d     = fault_q;
        err_count_d = err_count_q;
        if (illegal) begin
            err_d   = 1'b1;
            fault_d = 1'b1;
            if (err_count_q != '1) err_count_d = err_count_q + EW'(1);
        end else if (up_hit) begin
            mode_est_d  = 1'b1;
            dir_valid_d = 1'b1;
            sat_hi_d    = (up_x > MAX_X);
        end else begin
            mode_est_d  = 1'b0;
            dir_valid_d = 1'b1;
            sat_lo_d    = (dn_x < MIN_X);
        end
    end

    // NOTE: sequential state uses non-blocking assignments only, so all registers update together.
    always_ff @(posedge clk) begin
        prev_q <= mon.cnt;
        if (rst) begin
            state_q     <= ST_ARMED;
            mode_est_q  <= 1'b0;
            dir_valid_q <= 1'b0;
            sat_hi_q    <= 1'b0;
            sat_lo_q    <= 1'b0;
            err_q       <= 1'b0;
            fault_q     <= 1'b0;
            err_count_q <= '0;
        end else begin
            state_q     <= state_d;
            mode_est_q  <= mode_est_d;
            dir_valid_q <= dir_valid_d;
            sat_hi_q    <= sat_hi_d;
            sat_lo_q    <= sat_lo_d;
            err_q       <= err_d;
            fault_q     <= fault_d;
            err_count_q <= err_count_d;
        end
    end

    assign mon.mode_est  = mode_est_q;
    assign mon.dir_valid = dir_valid_q;
    assign mon.sat_hi    = sat_hi_q;
    assign mon.sat_lo    = sat_lo_q;
    assign mon.err       = err_q;
    assign mon.fault     = fault_q;
    assign mon.err_count = err_count_q;
endmodule

// File: tb/tb_counter_monitor.sv
// Directed bench for counter_monitor: legal walks, INV skips, saturation holds,
// glitches, error-tally saturation and mid-run reset, with hand-computed expectations.
module tb_counter_monitor;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_asserts = 0;
    int   n_fail    = 0;
    int   cur       = 0;

    counter_monitor_if #(.W(10), .EW(8)) mon_if ();

    counter_monitor dut (
        .clk (clk),
        .rst (rst),
        .mon (mon_if)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: time limit reached, got no summary, want finish");
        $fatal(1, "watchdog expired");
    end

    task automatic step(input int v);
        mon_if.cnt = 10'(v);
        cur = v;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset(input int v);
        rst = 1'b1;
        step(v);
        rst = 1'b0;
    endtask

    task automatic go_up(input int n);
        for (int i = 0; i < n; i++) step((cur + 5 == -11) ? -6 : cur + 5);
    endtask

    task automatic go_dn(input int n);
        for (int i = 0; i < n; i++) step((cur - 9 == -11) ? -20 : cur - 9);
    endtask

    task automatic test_reset;
        rst = 1'b1;
        step(-50);
        step(-50);
        n_asserts++; if (mon_if.err !== 1'b0) begin n_fail++; $display("FAIL rst_err: got %b want 0", mon_if.err); end
        n_asserts++; if (mon_if.fault !== 1'b0) begin n_fail++; $display("FAIL rst_fault: got %b want 0", mon_if.fault); end
        n_asserts++; if (mon_if.err_count !== 8'd0) begin n_fail++; $display("FAIL rst_count: got %0d want 0", mon_if.err_count); end
        n_asserts++; if ({mon_if.mode_est, mon_if.dir_valid, mon_if.sat_hi, mon_if.sat_lo} !== 4'b0000) begin n_fail++; $display("FAIL rst_flags: got %b want 0000", {mon_if.mode_est, mon_if.dir_valid, mon_if.sat_hi, mon_if.sat_lo}); end
        rst = 1'b0;
        step(-45);
        n_asserts++; if ({mon_if.mode_est, mon_if.dir_valid, mon_if.err} !== 3'b110) begin n_fail++; $display("FAIL first_up: got mode/dv/err=%b want 110", {mon_if.mode_est, mon_if.dir_valid, mon_if.err}); end
        step(-40);
        n_asserts++; if ({mon_if.mode_est, mon_if.dir_valid, mon_if.err} !== 3'b110) begin n_fail++; $display("FAIL second_up: got mode/dv/err=%b want 110", {mon_if.mode_est, mon_if.dir_valid, mon_if.err}); end
    endtask

    task automatic test_up_inv;
        do_reset(-50); go_dn(4); go_up(13);
        n_asserts++; if (mon_if.err_count !== 8'd0 || cur != -21) begin n_fail++; $display("FAIL walk_m21: got count=%0d cur=%0d want 0/-21", mon_if.err_count, cur); end
        step(-16);
        n_asserts++; if ({mon_if.mode_est, mon_if.err} !== 2'b10) begin n_fail++; $display("FAIL up_m16: got mode/err=%b want 10", {mon_if.mode_est, mon_if.err}); end
        step(-6);
        n_asserts++; if ({mon_if.mode_est, mon_if.dir_valid, mon_if.err} !== 3'b110) begin n_fail++; $display("FAIL up_skip_inv: got mode/dv/err=%b want 110", {mon_if.mode_est, mon_if.dir_valid, mon_if.err}); end
        do_reset(-50); go_dn(4); go_up(13); step(-16); step(-11);
        n_asserts++; if ({mon_if.err, mon_if.fault} !== 2'b11) begin n_fail++; $display("FAIL up_into_inv: got err/fault=%b want 11", {mon_if.err, mon_if.fault}); end
        n_asserts++; if (mon_if.err_count !== 8'd1) begin n_fail++; $display("FAIL up_into_inv_count: got %0d want 1", mon_if.err_count); end
        n_asserts++; if ({mon_if.mode_est, mon_if.dir_valid} !== 2'b10) begin n_fail++; $display("FAIL up_into_inv_hold: got mode/dv=%b want 10", {mon_if.mode_est, mon_if.dir_valid}); end
    endtask

    task automatic test_dn_inv;
        do_reset(-50); go_dn(2); go_up(15); step(-2);
        n_asserts++; if ({mon_if.mode_est, mon_if.err} !== 2'b00) begin n_fail++; $display("FAIL dn_m2: got mode/err=%b want 00", {mon_if.mode_est, mon_if.err}); end
        step(-20);
        n_asserts++; if ({mon_if.mode_est, mon_if.dir_valid, mon_if.err} !== 3'b010) begin n_fail++; $display("FAIL dn_skip_inv: got mode/dv/err=%b want 010", {mon_if.mode_est, mon_if.dir_valid, mon_if.err}); end
        do_reset(-50); go_dn(2); go_up(15); step(-2); step(-11);
        n_asserts++; if ({mon_if.err, mon_if.mode_est, mon_if.dir_valid} !== 3'b100) begin n_fail++; $display("FAIL dn_into_inv: got err/mode/dv=%b want 100", {mon_if.err, mon_if.mode_est, mon_if.dir_valid}); end
    endtask

    task automatic test_saturation;
        do_reset(-50); go_up(56); step(235);
        n_asserts++; if ({mon_if.sat_hi, mon_if.mode_est, mon_if.err} !== 3'b010) begin n_fail++; $display("FAIL up_to_max: got sat_hi/mode/err=%b want 010", {mon_if.sat_hi, mon_if.mode_est, mon_if.err}); end
        step(235);
        n_asserts++; if ({mon_if.sat_hi, mon_if.sat_lo, mon_if.mode_est, mon_if.dir_valid, mon_if.err} !== 5'b10110) begin n_fail++; $display("FAIL hold_hi1: got hi/lo/mode/dv/err=%b want 10110", {mon_if.sat_hi, mon_if.sat_lo, mon_if.mode_est, mon_if.dir_valid, mon_if.err}); end
        step(235);
        n_asserts++; if ({mon_if.sat_hi, mon_if.err} !== 2'b10) begin n_fail++; $display("FAIL hold_hi2: got sat_hi/err=%b want 10", {mon_if.sat_hi, mon_if.err}); end
        step(229); step(229);
        n_asserts++; if ({mon_if.err, mon_if.sat_hi, mon_if.dir_valid} !== 3'b100) begin n_fail++; $display("FAIL hold_229: got err/sat_hi/dv=%b want 100", {mon_if.err, mon_if.sat_hi, mon_if.dir_valid}); end
        n_asserts++; if (mon_if.err_count !== 8'd2) begin n_fail++; $display("FAIL hold_229_count: got %0d want 2", mon_if.err_count); end
        do_reset(-50); go_dn(19); step(-230);
        n_asserts++; if ({mon_if.sat_lo, mon_if.mode_est, mon_if.err} !== 3'b000) begin n_fail++; $display("FAIL dn_to_min: got sat_lo/mode/err=%b want 000", {mon_if.sat_lo, mon_if.mode_est, mon_if.err}); end
        step(-230);
        n_asserts++; if ({mon_if.sat_lo, mon_if.sat_hi, mon_if.mode_est, mon_if.dir_valid, mon_if.err} !== 5'b10010) begin n_fail++; $display("FAIL hold_lo: got lo/hi/mode/dv/err=%b want 10010", {mon_if.sat_lo, mon_if.sat_hi, mon_if.mode_est, mon_if.dir_valid, mon_if.err}); end
        step(-239);
        n_asserts++; if ({mon_if.err, mon_if.sat_lo} !== 2'b10) begin n_fail++; $display("FAIL below_min: got err/sat_lo=%b want 10", {mon_if.err, mon_if.sat_lo}); end
    endtask

    task automatic test_glitch;
        do_reset(-50); go_up(30); step(37);
        n_asserts++; if (mon_if.err !== 1'b1) begin n_fail++; $display("FAIL glitch_in: got err=%b want 1", mon_if.err); end
        step(110);
        n_asserts++; if (mon_if.err !== 1'b1) begin n_fail++; $display("FAIL glitch_out: got err=%b want 1", mon_if.err); end
        step(115);
        n_asserts++; if ({mon_if.err, mon_if.mode_est, mon_if.dir_valid} !== 3'b011) begin n_fail++; $display("FAIL glitch_recover: got err/mode/dv=%b want 011", {mon_if.err, mon_if.mode_est, mon_if.dir_valid}); end
        n_asserts++; if (mon_if.err_count !== 8'd2) begin n_fail++; $display("FAIL glitch_count: got %0d want 2", mon_if.err_count); end
    endtask

    task automatic test_err_saturation;
        for (int i = 0; i < 300; i++) begin
            step((i % 2 == 0) ? 100 : 0);
            if (i == 249) begin
                n_asserts++; if (mon_if.err_count !== 8'd252) begin n_fail++; $display("FAIL count_252: got %0d want 252", mon_if.err_count); end
            end
        end
        n_asserts++; if (mon_if.err_count !== 8'd255) begin n_fail++; $display("FAIL count_sat: got %0d want 255", mon_if.err_count); end
        n_asserts++; if ({mon_if.err, mon_if.fault} !== 2'b11) begin n_fail++; $display("FAIL count_sat_flags: got err/fault=%b want 11", {mon_if.err, mon_if.fault}); end
    endtask

    task automatic test_mid_reset;
        do_reset(-50); step(100);
        for (int i = 0; i < 6; i++) step((i % 2 == 0) ? 0 : 100);
        n_asserts++; if ({mon_if.fault, mon_if.err_count} !== {1'b1, 8'd7}) begin n_fail++; $display("FAIL pre_reset: got fault=%b count=%0d want 1/7", mon_if.fault, mon_if.err_count); end
        do_reset(-50);
        n_asserts++; if ({mon_if.mode_est, mon_if.dir_valid, mon_if.sat_hi, mon_if.sat_lo, mon_if.err, mon_if.fault, mon_if.err_count} !== 14'd0) begin n_fail++; $display("FAIL mid_reset_clear: got fault=%b count=%0d err=%b want all 0", mon_if.fault, mon_if.err_count, mon_if.err); end
        step(-45);
        n_asserts++; if ({mon_if.err, mon_if.fault, mon_if.err_count, mon_if.mode_est, mon_if.dir_valid} !== {2'b00, 8'd0, 2'b11}) begin n_fail++; $display("FAIL post_reset_step: got err=%b fault=%b count=%0d mode=%b dv=%b want 0/0/0/1/1", mon_if.err, mon_if.fault, mon_if.err_count, mon_if.mode_est, mon_if.dir_valid); end
        do_reset(-40); step(-35);
        n_asserts++; if ({mon_if.err, mon_if.fault, mon_if.dir_valid, mon_if.mode_est} !== 4'b1100) begin n_fail++; $display("FAIL bad_reset_val: got err/fault/dv/mode=%b want 1100", {mon_if.err, mon_if.fault, mon_if.dir_valid, mon_if.mode_est}); end
        n_asserts++; if (mon_if.err_count !== 8'd1) begin n_fail++; $display("FAIL bad_reset_count: got %0d want 1", mon_if.err_count); end
    endtask

    initial begin
        mon_if.cnt = 10'(-50);
        test_reset();
        test_up_inv();
        test_dn_inv();
        test_saturation();
        test_glitch();
        test_err_saturation();
        test_mid_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
        $finish;
    end
endmodule

// File: doc/counter_monitor.md
Name: counter_monitor

Overview:
- Passive receiver on the up/down counter's `cnt` bus (up step +5, down step −9, skip INV, saturate at MAX/MIN, reset value −50).
- Each cycle it compares the current sample with the previous one.
- It reconstructs the counting direction, flags illegal transitions and keeps a saturating error tally.
- It sits beside the counter in synthesis builds as a run-time health monitor, complementing the formal checks.

Parameters:
- W, 10, width of the signed count bus
- RST_VAL, -50, counter value while reset is asserted
- MIN, -230, lowest legal count
- MAX, 235, highest legal count
- INV, -11, forbidden count, skipped by the counter
- STEP_UP, 5, increment when mode=1
- STEP_DN, 9, decrement magnitude when mode=0
- EW, 8, width of the error counter

Ports:
- clk  input  1  clock
- rst  input  1  synchronous active-high reset
- cnt  input  W signed  counter output, sampled every posedge
- mode_est  output  1  reconstructed direction of the last step (1 = up)
- dir_valid  output  1  mode_est is meaningful
- sat_hi  output  1  last step was a hold in the up-saturation band
- sat_lo  output  1  last step was a hold in the down-saturation band
- err  output  1  one-cycle pulse: last observed transition illegal
- fault  output  1  sticky; set on first err, cleared only by rst
- err_count  output  EW  number of err pulses, saturates at 2^EW−1

Behaviour:
- All outputs are registered.
- Reset:
  - While rst=1 at a posedge, every output goes to 0.
  - prev <= cnt, and state <= ARMED.
  - If cnt != RST_VAL during rst, then at the first non-reset edge err=1, fault=1 and err_count=1. No other checks are done on that edge.
- States:
  - ARMED: first edge after reset.
  - TRACK: normal operation.
  - ARMED → TRACK on the first non-reset edge, unconditionally.
  - Both states evaluate the transition below.
  - rst in any state returns to ARMED; it also clears fault and err_count mid-operation.
- Transition check, at each non-reset edge with p = prev and c = cnt, all arithmetic signed at W+2 bits:
  - Legal up: c == p+STEP_UP, with p+STEP_UP <= MAX and p+STEP_UP != INV.
  - Legal up over INV: p+STEP_UP == INV and c == p+2·STEP_UP (−16 → −6).
  - Legal up hold: p+STEP_UP > MAX (p in 231..235) and c == p. Sets sat_hi=1.
  - Legal down: c == p−STEP_DN, with p−STEP_DN >= MIN and p−STEP_DN != INV.
  - Legal down over INV: p−STEP_DN == INV and c == p−2·STEP_DN (−2 → −20).
  - Legal down hold: p−STEP_DN < MIN (p in −230..−222) and c == p. Sets sat_lo=1.
  - Any up rule matched: mode_est=1, dir_valid=1.
  - Any down rule matched: mode_est=0, dir_valid=1.
  - No rule matched, or c outside [MIN, MAX], or c == INV:
    - err=1, dir_valid=0, mode_est holds its previous value
    - fault=1; err_count increments, no wrap
- The up and down rules cannot both match for the default parameters. If an override makes them overlap, up takes priority.
- prev <= cnt on every edge, including error edges, so a single glitch produces at most 2 err pulses.
- Latency: outputs at edge k+1 reflect the transition from sample k−1 to sample k.
- sat_hi and sat_lo are 0 on any edge that is not a hold. They are never both 1.

Test Plan:
- Reset sequence, then rst=0:
  - Stimulus: cnt=−50 during rst, then −45, −40.
  - Required: mode_est=1, dir_valid=1, err=0.
- Up across INV:
  - Stimulus: cnt −21, −16, −6.
  - Required: no err; mode_est=1 at each step.
  - Then force cnt −16 → −11: err=1, fault=1, err_count=1.
- Down across INV:
  - Stimulus: cnt 7, −2, −20.
  - Required: mode_est=0, err=0.
  - Then force −2 → −11: err=1.
- Saturation:
  - Stimulus: 230 → 235 → 235 → 235.
  - Required: sat_hi=1 on the hold edges, mode_est=1.
  - Stimulus: −221 → −230 → −230.
  - Required: sat_lo=1, mode_est=0.
  - Stimulus: 229 → 229 (not in the up band).
  - Required: err=1.
- Glitch and error saturation:
  - Stimulus: single glitch 100 → 37 → 110.
  - Required: 2 err pulses, err_count=2.
  - Stimulus: 300 consecutive illegal samples.
  - Required: err_count stops at 255.
- Mid-run reset:
  - Stimulus: with fault=1 and err_count=7, assert rst for 1 cycle with cnt=−50.
  - Required: all outputs 0; the next legal step gives no err.
  - Stimulus: reset with cnt=−40.
  - Required: err=1 on the first post-reset edge.
